// File: rtl/count_pkg.sv
// Shared types for the JK-flip-flop counter: counter width, count type and JK function encoding.
package count_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Encoding matches {j, k} so a flop can cast its inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

endpackage

// File: rtl/jk_ff.sv
// JK flip-flop with asynchronous active-high reset and complementary outputs.
module jk_ff
  import count_pkg::*;
(
  input  logic clk,
  input  logic rs,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  jk_op_e op;

  assign op = jk_op_e'({j, k});
  assign qn = ~q;

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      q <= 1'b0;
    end else begin
      unique case (op)
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/count4bit_jk.sv
// Synchronous binary up-counter built from toggle-mode JK flip-flops sharing one clock.
module count4bit_jk
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             jk_clk,
  input  logic             jk_rs,
  output logic [WIDTH-1:0] jk_q
);

  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] qn;

  // Stage i toggles only when every lower stage is 1; the chain reuses qn so each
  // stage needs just one extra AND term.
  assign tgl[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign tgl[i] = tgl[i-1] & ~qn[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_ff u_jk_ff (
      .clk (jk_clk),
      .rs  (jk_rs),
      .j   (tgl[i]),
      .k   (tgl[i]),
      .q   (jk_q[i]),
      .qn  (qn[i])
    );
  end

endmodule

// File: tb/tb_count4bit_jk.sv
// Scoreboard bench for count4bit_jk: expected counts are queued per edge and compared after it.
module tb_count4bit_jk;
  import count_pkg::*;

  logic jk_clk;
  logic jk_rs;
  cnt_t jk_q;

  count4bit_jk #(.WIDTH(CNT_W)) dut (
    .jk_clk (jk_clk),
    .jk_rs  (jk_rs),
    .jk_q   (jk_q)
  );

  initial jk_clk = 1'b0;
  always #5 jk_clk = ~jk_clk;

  int   checks = 0;
  int   errors = 0;
  cnt_t model;
  cnt_t exp_q[$];
  int   tog[CNT_W];
  cnt_t prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the expected value for the coming edge, clock, then pop and compare.
  task automatic edge_step(input string tag);
    cnt_t exp;
    model = jk_rs ? cnt_t'(0) : cnt_t'(model + 1'b1);
    exp_q.push_back(model);
    prev = jk_q;
    @(posedge jk_clk);
    #1;
    for (int b = 0; b < CNT_W; b++) if (jk_q[b] !== prev[b]) tog[b]++;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {28'd0, jk_q}, {28'd0, exp});
    end
  endtask

  task automatic assert_reset(input string tag);
    @(negedge jk_clk);
    #2;
    jk_rs = 1'b1;
    #1;
    model = '0;
    check_eq(tag, {28'd0, jk_q}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge jk_clk);
    jk_rs = 1'b0;
    #1;
    check_eq("rst_release_hold", {28'd0, jk_q}, 32'd0);
  endtask

  initial begin
    jk_rs = 1'b0;
    model = '0;
    for (int b = 0; b < CNT_W; b++) tog[b] = 0;

    // Reset at start, held across two edges
    assert_reset("rst_async_initial");
    edge_step("rst_hold0");
    edge_step("rst_hold1");
    release_reset();
    edge_step("post_rst_1");
    edge_step("post_rst_2");

    // Full sequence 1..15,0 then wrap to 1
    assert_reset("rst_seq");
    release_reset();
    for (int i = 0; i < 16; i++) edge_step("full_seq");
    check_eq("wrap_zero", {28'd0, jk_q}, 32'd0);
    edge_step("wrap_next");
    check_eq("wrap_one", {28'd0, jk_q}, 32'd1);

    // Async reset mid-count at 9
    assert_reset("rst_pre_mid");
    release_reset();
    for (int i = 0; i < 9; i++) edge_step("count_to_9");
    check_eq("at_nine", {28'd0, jk_q}, 32'd9);
    assert_reset("rst_async_mid");
    for (int i = 0; i < 3; i++) edge_step("rst_mid_hold");
    release_reset();
    for (int i = 0; i < 3; i++) edge_step("resume");
    check_eq("resume_three", {28'd0, jk_q}, 32'd3);

    // Divider: toggles per bit over 32 edges
    assert_reset("rst_div");
    release_reset();
    for (int b = 0; b < CNT_W; b++) tog[b] = 0;
    for (int i = 0; i < 32; i++) edge_step("div_run");
    check_eq("tog_bit0", tog[0], 32'd32);
    check_eq("tog_bit1", tog[1], 32'd16);
    check_eq("tog_bit2", tog[2], 32'd8);
    check_eq("tog_bit3", tog[3], 32'd4);

    // Long run of 100 edges
    assert_reset("rst_long");
    release_reset();
    for (int i = 0; i < 100; i++) edge_step("long_run");
    check_eq("long_final", {28'd0, jk_q}, 32'd4);

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
